// File: rtl/dcache_miss_handler_if.sv
// Backend request/response, memory fill bus and hazard-flag bundle for the
// data-cache miss handler. The handler is the slave; backend and memory are the master.
interface dcache_miss_handler_if #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 8
);
  localparam int IDX_W = $clog2(LINE_BEATS);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              hit;
  logic [DATA_W-1:0] hit_rdata;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_data;
  logic              fill_we;
  logic [IDX_W-1:0]  fill_index;
  logic [DATA_W-1:0] fill_data;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              data_missed1;
  logic              data_busy;
  logic              data_finished1;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, hit, hit_rdata,
           bus_ack, bus_resp_valid, bus_resp_data,
    input  bus_req, bus_addr, fill_we, fill_index, fill_data,
           resp_valid, resp_data, data_missed1, data_busy, data_finished1
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, hit, hit_rdata,
           bus_ack, bus_resp_valid, bus_resp_data,
    output bus_req, bus_addr, fill_we, fill_index, fill_data,
           resp_valid, resp_data, data_missed1, data_busy, data_finished1
  );
endinterface

// File: rtl/dcache_miss_handler.sv
// Blocking data-cache miss handler: serves hits, fetches a whole line on a miss
// (critical word merged with store data) and raises hazard flags for the pipeline.
module dcache_miss_handler #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 8
) (
  input logic                  clk,
  input logic                  reset,
  dcache_miss_handler_if.slave io
);
  localparam int IDX_W  = $clog2(LINE_BEATS);
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int LINE_W = IDX_W + OFF_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((64'd1 << LINE_W) - 64'd1));
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MISS = 3'd1,
    REQ  = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_r, state_next_s;
  logic [IDX_W-1:0]  cnt_r, cnt_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] cap_r, cap_next_s;
  logic              crit_s, hit_take_s, fill_we_s;
  logic [DATA_W-1:0] fill_data_s;
  logic              resp_valid_r, bus_req_r, missed_r, busy_r, finished_r;
  logic [DATA_W-1:0] resp_data_r;
  logic [ADDR_W-1:0] bus_addr_r;

  // Next-state, beat counter, critical-word capture and fill-port decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cap_next_s   = cap_r;
    hit_take_s   = 1'b0;
    fill_we_s    = 1'b0;
    fill_data_s  = {DATA_W{1'b0}};
    crit_s       = (cnt_r == addr_r[LINE_W-1:OFF_W]);
    case (state_r)
      IDLE: begin
        if (io.req_valid && io.hit) begin
          hit_take_s = 1'b1;
        end else if (io.req_valid) begin
          state_next_s = MISS;
        end else begin
          state_next_s = IDLE;
        end
      end
      MISS: state_next_s = REQ;
      REQ: begin
        // A beat arriving with the ack is dropped; memory must resend it.
        if (io.bus_ack) begin
          state_next_s = FILL;
          cnt_next_s   = {IDX_W{1'b0}};
        end else begin
          state_next_s = REQ;
        end
      end
      FILL: begin
        if (io.bus_resp_valid) begin
          fill_we_s   = 1'b1;
          fill_data_s = (crit_s && write_r) ? wdata_r : io.bus_resp_data;
          if (crit_s && !write_r) begin
            cap_next_s = io.bus_resp_data;
          end else begin
            cap_next_s = cap_r;
          end
          cnt_next_s   = cnt_r + 1'b1;
          state_next_s = (cnt_r == LAST_IDX) ? DONE : FILL;
        end else begin
          state_next_s = FILL;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, request latches and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {IDX_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      write_r      <= 1'b0;
      wdata_r      <= {DATA_W{1'b0}};
      cap_r        <= {DATA_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      bus_req_r    <= 1'b0;
      bus_addr_r   <= {ADDR_W{1'b0}};
      missed_r     <= 1'b0;
      busy_r       <= 1'b0;
      finished_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      cap_r   <= cap_next_s;
      if (state_r == IDLE && io.req_valid && !io.hit) begin
        addr_r  <= io.req_addr;
        write_r <= io.req_write;
        wdata_r <= io.req_wdata;
      end else begin
        addr_r  <= addr_r;
        write_r <= write_r;
        wdata_r <= wdata_r;
      end
      resp_valid_r <= hit_take_s || (state_next_s == DONE);
      if (hit_take_s) begin
        resp_data_r <= io.req_write ? {DATA_W{1'b0}} : io.hit_rdata;
      end else if (state_next_s == DONE && !write_r) begin
        resp_data_r <= cap_next_s;
      end else begin
        resp_data_r <= {DATA_W{1'b0}};
      end
      bus_req_r  <= (state_next_s == REQ);
      bus_addr_r <= (state_next_s == REQ) ? (addr_r & LINE_MASK) : {ADDR_W{1'b0}};
      missed_r   <= (state_next_s == MISS);
      busy_r     <= (state_next_s == REQ) || (state_next_s == FILL);
      finished_r <= (state_next_s == DONE);
    end
  end

  assign io.bus_req        = bus_req_r;
  assign io.bus_addr       = bus_addr_r;
  assign io.fill_we        = fill_we_s;
  assign io.fill_index     = fill_we_s ? cnt_r : {IDX_W{1'b0}};
  assign io.fill_data      = fill_data_s;
  assign io.resp_valid     = resp_valid_r;
  assign io.resp_data      = resp_data_r;
  assign io.data_missed1   = missed_r;
  assign io.data_busy      = busy_r;
  assign io.data_finished1 = finished_r;
endmodule
